// File: rtl/omr_pkg.sv
// Shared constants and enumerations for the OMR sheet capture stage.
// Build option: OMR_MULTIMARK_REJECT_EN (see omr_row_classify).
package omr_pkg;

    localparam int NUM_Q = 10;
    localparam int OPT_W = 4;
    localparam int ANS_W = NUM_Q * OPT_W;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        BLANK,
        SINGLE,
        MULTI
    } row_class_t;

endpackage

// File: rtl/omr_row_classify.sv
// Combinational row classifier: maps raw bubble bits to a class and the value to store.
// With OMR_MULTIMARK_REJECT_EN defined, multi-mark rows are flagged and stored as zero.
module omr_row_classify #(
    parameter int OPT_W = omr_pkg::OPT_W
) (
    input  logic [OPT_W-1:0] row_marks,
    output logic [1:0]       row_class,
    output logic [OPT_W-1:0] row_stored
);
    import omr_pkg::*;

    always_comb begin
        row_class  = SINGLE;
        row_stored = row_marks;
        if (row_marks == '0) begin
            row_class = BLANK;
`ifdef OMR_MULTIMARK_REJECT_EN
        // Clearing the lowest set bit leaves something only when two or more bits are set.
        end else if ((row_marks & (row_marks - OPT_W'(1))) != '0) begin
            row_class  = MULTI;
            row_stored = '0;
`endif
        end
    end

endmodule

// File: rtl/omr_sheet_capture.sv
// Assembles serial answer rows into a sheet vector and holds it behind valid/ready.
// Build option: OMR_MULTIMARK_REJECT_EN zeroes multi-mark rows and counts them.
module omr_sheet_capture #(
    parameter int NUM_Q = omr_pkg::NUM_Q,
    parameter int OPT_W = omr_pkg::OPT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     sheet_start,
    input  logic                     row_valid,
    input  logic [OPT_W-1:0]         row_marks,
    input  logic                     out_ready,
    output logic                     sheet_valid,
    output logic [NUM_Q*OPT_W-1:0]   student_answers,
    output logic [3:0]               q_count,
    output logic [3:0]               blank_count,
    output logic [3:0]               multi_count,
    output logic                     row_overrun,
    output logic                     busy
);
    import omr_pkg::*;

    localparam int         SHEET_W  = NUM_Q * OPT_W;
    localparam logic [3:0] LAST_ROW = 4'(NUM_Q - 1);

    state_t               state_reg, state_next;
    logic [SHEET_W-1:0]   answers_reg, answers_next;
    logic [3:0]           q_count_reg, q_count_next;
    logic [3:0]           blank_count_reg, blank_count_next;
    logic [3:0]           multi_count_reg, multi_count_next;
    logic                 row_overrun_reg, row_overrun_next;
    logic                 sheet_valid_reg, sheet_valid_next;
    logic                 busy_reg, busy_next;

    logic [1:0]           row_class;
    logic [OPT_W-1:0]     row_stored;

    omr_row_classify #(
        .OPT_W(OPT_W)
    ) u_classify (
        .row_marks (row_marks),
        .row_class (row_class),
        .row_stored(row_stored)
    );

    always_comb begin
        state_next       = state_reg;
        answers_next     = answers_reg;
        q_count_next     = q_count_reg;
        blank_count_next = blank_count_reg;
        multi_count_next = multi_count_reg;
        // Overrun is sticky; only reset clears it.
        row_overrun_next = row_overrun_reg | (row_valid && (state_reg != COLLECT));

        unique case (state_reg)
            IDLE: begin
                if (sheet_start) begin
                    state_next       = COLLECT;
                    answers_next     = '0;
                    q_count_next     = '0;
                    blank_count_next = '0;
                    multi_count_next = '0;
                end
            end
            COLLECT: begin
                // A restart wins over a row arriving in the same cycle.
                if (sheet_start) begin
                    answers_next     = '0;
                    q_count_next     = '0;
                    blank_count_next = '0;
                    multi_count_next = '0;
                end else if (row_valid) begin
                    for (int i = 0; i < NUM_Q; i++) begin
                        if (q_count_reg == 4'(NUM_Q - 1 - i)) begin
                            answers_next[i*OPT_W +: OPT_W] = row_stored;
                        end
                    end
                    q_count_next = q_count_reg + 4'd1;
                    if (row_class == BLANK) begin
                        blank_count_next = blank_count_reg + 4'd1;
                    end
`ifdef OMR_MULTIMARK_REJECT_EN
                    if (row_class == MULTI) begin
                        multi_count_next = multi_count_reg + 4'd1;
                    end
`endif
                    if (q_count_reg == LAST_ROW) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (sheet_valid_reg && out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        sheet_valid_next = (state_next == HOLD);
        busy_next        = (state_next == COLLECT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            answers_reg     <= '0;
            q_count_reg     <= '0;
            blank_count_reg <= '0;
            multi_count_reg <= '0;
            row_overrun_reg <= 1'b0;
            sheet_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            answers_reg     <= answers_next;
            q_count_reg     <= q_count_next;
            blank_count_reg <= blank_count_next;
            multi_count_reg <= multi_count_next;
            row_overrun_reg <= row_overrun_next;
            sheet_valid_reg <= sheet_valid_next;
            busy_reg        <= busy_next;
        end
    end

    assign sheet_valid     = sheet_valid_reg;
    assign student_answers = answers_reg;
    assign q_count         = q_count_reg;
    assign blank_count     = blank_count_reg;
    assign multi_count     = multi_count_reg;
    assign row_overrun     = row_overrun_reg;
    assign busy            = busy_reg;

endmodule
